// File: rtl/gci_std_display_vram_arbiter_if.sv
// Signal bundle between the VRAM arbiter, its three masters and the VRAM port.
// Names keep the arbiter's point of view (i* = into the arbiter, o* = out of it).
interface gci_std_display_vram_arbiter_if;
  logic        iRD_REQ;
  logic [18:0] iRD_ADDR;
  logic        oRD_BUSY;
  logic        oRD_VALID;
  logic [15:0] oRD_DATA;

  logic        iWR0_REQ;
  logic [18:0] iWR0_ADDR;
  logic [15:0] iWR0_DATA;
  logic        oWR0_WAIT;

  logic        iWR1_REQ;
  logic [18:0] iWR1_ADDR;
  logic [15:0] iWR1_DATA;
  logic        oWR1_WAIT;

  logic        oMEM_REQ;
  logic        oMEM_WR;
  logic [18:0] oMEM_ADDR;
  logic [15:0] oMEM_DATA;
  logic        iMEM_BUSY;
  logic        iMEM_RD_VALID;
  logic [15:0] iMEM_RD_DATA;

  // Arbiter side.
  modport slave (
    input  iRD_REQ, iRD_ADDR,
    output oRD_BUSY, oRD_VALID, oRD_DATA,
    input  iWR0_REQ, iWR0_ADDR, iWR0_DATA,
    output oWR0_WAIT,
    input  iWR1_REQ, iWR1_ADDR, iWR1_DATA,
    output oWR1_WAIT,
    output oMEM_REQ, oMEM_WR, oMEM_ADDR, oMEM_DATA,
    input  iMEM_BUSY, iMEM_RD_VALID, iMEM_RD_DATA
  );

  // Environment side: scan-out, write masters and VRAM together.
  modport master (
    output iRD_REQ, iRD_ADDR,
    input  oRD_BUSY, oRD_VALID, oRD_DATA,
    output iWR0_REQ, iWR0_ADDR, iWR0_DATA,
    input  oWR0_WAIT,
    output iWR1_REQ, iWR1_ADDR, iWR1_DATA,
    input  oWR1_WAIT,
    input  oMEM_REQ, oMEM_WR, oMEM_ADDR, oMEM_DATA,
    output iMEM_BUSY, iMEM_RD_VALID, iMEM_RD_DATA
  );
endinterface

// File: rtl/gci_std_display_vram_arbiter.sv
// VRAM port arbiter: scan-out read bursts take priority, the two write masters
// share round-robin slots of up to P_WR_SLOT writes.
module gci_std_display_vram_arbiter #(
  parameter int P_BURST      = 16,
  parameter int P_WR_SLOT    = 32,
  parameter int P_VRAM_WORDS = 307200
) (
  input  logic                                iCLOCK,
  input  logic                                inRESET,
  gci_std_display_vram_arbiter_if.slave       bus
);

  localparam int CW = $clog2(P_BURST + 1);
  localparam int SW = $clog2(P_WR_SLOT + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(P_BURST - 1);
  localparam logic [SW-1:0] SLOT_MAX   = SW'(P_WR_SLOT);
  localparam logic [18:0]   ADDR_LAST  = 19'(P_VRAM_WORDS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WR0, ST_WR1} state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;            // 0: WR0 wins a tie, 1: WR1 wins
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic          rd_pending_q, rd_pending_d;
  logic          rd_busy_q, rd_busy_d;
  logic [18:0]   rd_addr_q, rd_addr_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] ret_cnt_q, ret_cnt_d;
  logic          rd_valid_q, rd_valid_d;
  logic [15:0]   rd_data_q, rd_data_d;

  logic          mem_req, mem_wr, wr0_wait, wr1_wait, mem_take;
  logic [18:0]   mem_addr;
  logic [15:0]   mem_data;
  logic          cur_req, rd_issue, ret_ok;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    slot_cnt_d = slot_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_pending_q)                        state_d = ST_READ;
        else if (bus.iWR0_REQ && bus.iWR1_REQ)   state_d = rr_q ? ST_WR1 : ST_WR0;
        else if (bus.iWR0_REQ)                   state_d = ST_WR0;
        else if (bus.iWR1_REQ)                   state_d = ST_WR1;
      end
      ST_READ: begin
        if (mem_take && issue_cnt_q == BURST_LAST) state_d = ST_IDLE;
      end
      default: begin
        // The write seen together with the exit condition still counts.
        if (mem_take) slot_cnt_d = slot_cnt_q + 1'b1;
        if (slot_cnt_d == SLOT_MAX || !cur_req || rd_pending_q) begin
          state_d    = ST_IDLE;
          rr_d       = (state_q == ST_WR0);
          slot_cnt_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    wr0_wait = 1'b1;
    wr1_wait = 1'b1;
    case (state_q)
      ST_READ: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr_q;
      end
      ST_WR0: begin
        mem_req  = bus.iWR0_REQ;
        mem_wr   = 1'b1;
        mem_addr = bus.iWR0_ADDR;
        mem_data = bus.iWR0_DATA;
        wr0_wait = bus.iMEM_BUSY;
      end
      ST_WR1: begin
        mem_req  = bus.iWR1_REQ;
        mem_wr   = 1'b1;
        mem_addr = bus.iWR1_ADDR;
        mem_data = bus.iWR1_DATA;
        wr1_wait = bus.iMEM_BUSY;
      end
      default: ;
    endcase
  end

  assign mem_take = mem_req && !bus.iMEM_BUSY;
  assign cur_req  = (state_q == ST_WR1) ? bus.iWR1_REQ : bus.iWR0_REQ;
  assign rd_issue = (state_q == ST_READ) && mem_take;
  // Returns are accepted only while some issued read is still unanswered.
  assign ret_ok   = bus.iMEM_RD_VALID && (ret_cnt_q < issue_cnt_q);

  always_comb begin
    rd_pending_d = rd_pending_q;
    rd_busy_d    = rd_busy_q;
    rd_addr_d    = rd_addr_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    if (rd_issue) begin
      rd_addr_d   = (rd_addr_q == ADDR_LAST) ? '0 : rd_addr_q + 1'b1;
      issue_cnt_d = issue_cnt_q + 1'b1;
      if (issue_cnt_q == BURST_LAST) rd_pending_d = 1'b0;
    end
    if (ret_ok) begin
      ret_cnt_d = ret_cnt_q + 1'b1;
      if (ret_cnt_q == BURST_LAST) begin
        rd_busy_d   = 1'b0;
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
      end
    end
    if (bus.iRD_REQ && !rd_busy_q) begin
      rd_pending_d = 1'b1;
      rd_busy_d    = 1'b1;
      rd_addr_d    = bus.iRD_ADDR;
      issue_cnt_d  = '0;
      ret_cnt_d    = '0;
    end
    rd_valid_d = ret_ok;
    rd_data_d  = ret_ok ? bus.iMEM_RD_DATA : rd_data_q;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rr_q         <= 1'b0;
      slot_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      rd_busy_q    <= 1'b0;
      rd_addr_q    <= '0;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      rr_q         <= rr_d;
      slot_cnt_q   <= slot_cnt_d;
      rd_pending_q <= rd_pending_d;
      rd_busy_q    <= rd_busy_d;
      rd_addr_q    <= rd_addr_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign bus.oRD_BUSY  = rd_busy_q;
  assign bus.oRD_VALID = rd_valid_q;
  assign bus.oRD_DATA  = rd_data_q;
  assign bus.oWR0_WAIT = wr0_wait;
  assign bus.oWR1_WAIT = wr1_wait;
  assign bus.oMEM_REQ  = mem_req;
  assign bus.oMEM_WR   = mem_wr;
  assign bus.oMEM_ADDR = mem_addr;
  assign bus.oMEM_DATA = mem_data;

  // A scan-out request while a burst is still pending is a protocol error.
  rd_req_while_busy: assert property (@(posedge iCLOCK) disable iff (!inRESET)
    !(bus.iRD_REQ && rd_busy_q));

endmodule

// File: tb/tb_gci_std_display_vram_arbiter.sv
// Directed self-checking bench for the VRAM arbiter: reset, round-robin,
// read burst with address wrap, preemption, stalls and reset mid-burst.
module tb_gci_std_display_vram_arbiter;
  localparam int BURST = 16;
  localparam int SLOT  = 32;
  localparam int WORDS = 307200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gci_std_display_vram_arbiter_if bus();

  gci_std_display_vram_arbiter #(
    .P_BURST(BURST), .P_WR_SLOT(SLOT), .P_VRAM_WORDS(WORDS)
  ) dut (
    .iCLOCK (clk),
    .inRESET(rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { int due; logic [15:0] d; } ret_t;

  ret_t        ret_q[$];
  logic [18:0] rlog[$];
  logic [15:0] rdout[$];
  logic        busy_at_val[$];
  int          codes[$];          // per cycle: 0/1 write by WRn, 2 read issue, 3 no access
  int          wr_left[2];
  logic [18:0] wr_addr[2];
  logic [15:0] wr_data[2];
  int          acc[2];
  bit          took[2];
  int          wr_err;
  int          cyc_n = 0;
  bit          stray = 1'b0;

  function automatic logic [15:0] mem_val(input logic [18:0] a);
    return a[15:0] ^ {a[18:16], 13'h1A5A};
  endfunction

  function automatic logic [18:0] wrap_add(input logic [18:0] b, input int i);
    int s;
    s = int'(b) + i;
    if (s >= WORDS) s -= WORDS;
    return 19'(s);
  endfunction

  function automatic int count_code(input int c, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++)
      if (i >= 0 && i < codes.size() && codes[i] == c) n++;
    return n;
  endfunction

  function automatic int code_at(input int i);
    return (i >= 0 && i < codes.size()) ? codes[i] : -1;
  endfunction

  task automatic clear_logs();
    rlog.delete();
    rdout.delete();
    busy_at_val.delete();
    codes.delete();
    acc[0] = 0;
    acc[1] = 0;
    wr_err = 0;
  endtask

  // Drive this cycle's inputs, then observe the settled outputs.
  task automatic cyc_begin();
    int   code;
    ret_t r;
    bus.iWR0_REQ  = (wr_left[0] > 0);
    bus.iWR0_ADDR = wr_addr[0];
    bus.iWR0_DATA = wr_data[0];
    bus.iWR1_REQ  = (wr_left[1] > 0);
    bus.iWR1_ADDR = wr_addr[1];
    bus.iWR1_DATA = wr_data[1];
    bus.iMEM_RD_VALID = 1'b0;
    bus.iMEM_RD_DATA  = 16'h0;
    if (stray) begin
      bus.iMEM_RD_VALID = 1'b1;
      bus.iMEM_RD_DATA  = 16'hDEAD;
    end else if (ret_q.size() > 0 && ret_q[0].due <= cyc_n) begin
      r = ret_q.pop_front();
      bus.iMEM_RD_VALID = 1'b1;
      bus.iMEM_RD_DATA  = r.d;
    end
    #1;
    took[0] = bus.iWR0_REQ && !bus.oWR0_WAIT;
    took[1] = bus.iWR1_REQ && !bus.oWR1_WAIT;
    code = 3;
    if (took[0] && took[1]) wr_err++;
    if (bus.oMEM_REQ && !bus.iMEM_BUSY) begin
      if (bus.oMEM_WR) begin
        if (took[0]) begin
          code = 0;
          if (bus.oMEM_ADDR !== wr_addr[0] || bus.oMEM_DATA !== wr_data[0]) wr_err++;
        end else if (took[1]) begin
          code = 1;
          if (bus.oMEM_ADDR !== wr_addr[1] || bus.oMEM_DATA !== wr_data[1]) wr_err++;
        end else wr_err++;
      end else begin
        code = 2;
        if (took[0] || took[1]) wr_err++;
        rlog.push_back(bus.oMEM_ADDR);
        r.due = cyc_n + 2;
        r.d   = mem_val(bus.oMEM_ADDR);
        ret_q.push_back(r);
      end
    end else if (took[0] || took[1]) wr_err++;
    codes.push_back(code);
    if (bus.oRD_VALID) begin
      rdout.push_back(bus.oRD_DATA);
      busy_at_val.push_back(bus.oRD_BUSY);
    end
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
    cyc_n++;
    for (int n = 0; n < 2; n++)
      if (took[n]) begin
        wr_left[n]--;
        acc[n]++;
        wr_addr[n] = wr_addr[n] + 19'd1;
        wr_data[n] = wr_data[n] + 16'h1111;
      end
  endtask

  task automatic cycle();
    cyc_begin();
    cyc_end();
  endtask

  // Run until the read burst completes, then take the cycle holding the last return.
  task automatic wait_rd_done(input string tag, input int budget);
    int n = 0;
    while (bus.oRD_BUSY && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_timeout"}, bus.oRD_BUSY, 1'b0);
    cycle();
  endtask

  task automatic check_burst(input string tag, input logic [18:0] base);
    int ea = 0;
    int ed = 0;
    for (int i = 0; i < rlog.size(); i++)
      if (rlog[i] !== wrap_add(base, i)) ea++;
    for (int i = 0; i < rdout.size(); i++)
      if (rdout[i] !== mem_val(wrap_add(base, i))) ed++;
    check({tag, "_issues"}, rlog.size(), BURST);
    check({tag, "_addr_err"}, ea, 0);
    check({tag, "_returns"}, rdout.size(), BURST);
    check({tag, "_data_err"}, ed, 0);
    check({tag, "_busy_last"},  (busy_at_val.size() == BURST) ? busy_at_val[BURST-1] : 1'bx, 1'b0);
    check({tag, "_busy_prev"},  (busy_at_val.size() == BURST) ? busy_at_val[BURST-2] : 1'bx, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first2, last2, n;
    bit rd_sent;

    bus.iRD_REQ = 1'b0;  bus.iRD_ADDR = '0;
    bus.iWR0_REQ = 1'b0; bus.iWR0_ADDR = '0; bus.iWR0_DATA = '0;
    bus.iWR1_REQ = 1'b0; bus.iWR1_ADDR = '0; bus.iWR1_DATA = '0;
    bus.iMEM_BUSY = 1'b0; bus.iMEM_RD_VALID = 1'b0; bus.iMEM_RD_DATA = '0;
    wr_addr[0] = 19'h01000; wr_data[0] = 16'h1000;
    wr_addr[1] = 19'h20000; wr_data[1] = 16'h8000;
    wr_left[0] = 64;        wr_left[1] = 32;
    clear_logs();

    // T1: reset held with every request asserted
    rst_n = 1'b0;
    bus.iRD_REQ = 1'b1;
    @(posedge clk); #1;
    cycle();
    cycle();
    check("rst_mem_req",  bus.oMEM_REQ, 1'b0);
    check("rst_mem_wr",   bus.oMEM_WR, 1'b0);
    check("rst_mem_addr", bus.oMEM_ADDR, 19'h0);
    check("rst_mem_data", bus.oMEM_DATA, 16'h0);
    check("rst_wait0",    bus.oWR0_WAIT, 1'b1);
    check("rst_wait1",    bus.oWR1_WAIT, 1'b1);
    check("rst_rd_busy",  bus.oRD_BUSY, 1'b0);
    check("rst_rd_valid", bus.oRD_VALID, 1'b0);
    check("rst_rd_data",  bus.oRD_DATA, 16'h0);
    check("rst_no_write", acc[0] + acc[1], 0);
    bus.iRD_REQ = 1'b0;
    clear_logs();
    rst_n = 1'b1;

    // T3: both write masters requesting continuously
    for (int i = 0; i < 105; i++) cycle();
    check("rr_c0_idle",   code_at(0), 3);
    check("rr_wr0_slot1", count_code(0, 1, 32), 32);
    check("rr_gap1",      code_at(33), 3);
    check("rr_wr1_slot",  count_code(1, 34, 65), 32);
    check("rr_gap2",      code_at(66), 3);
    check("rr_wr0_slot2", count_code(0, 67, 98), 32);
    check("rr_end_idle",  code_at(99), 3);
    check("rr_wr_err",    wr_err, 0);
    check("rr_left",      wr_left[0] + wr_left[1], 0);

    // T2: read burst wrapping at the top of VRAM
    clear_logs();
    bus.iRD_REQ  = 1'b1;
    bus.iRD_ADDR = 19'h4AFF8;
    check("t2_busy_pre", bus.oRD_BUSY, 1'b0);
    cycle();
    bus.iRD_REQ = 1'b0;
    check("t2_busy_set", bus.oRD_BUSY, 1'b1);
    wait_rd_done("t2", 80);
    check("t2_addr7", (rlog.size() > 8) ? rlog[7] : 19'hx, 19'h4AFFF);
    check("t2_addr8", (rlog.size() > 8) ? rlog[8] : 19'hx, 19'h00000);
    check_burst("t2", 19'h4AFF8);

    // T4: read request during the 5th write of WR0
    clear_logs();
    wr_left[0] = 40;
    rd_sent = 1'b0;
    n = 0;
    while (!(rd_sent && wr_left[0] == 0 && !bus.oRD_BUSY) && n < 200) begin
      if (acc[0] == 4 && !rd_sent) begin
        bus.iRD_REQ  = 1'b1;
        bus.iRD_ADDR = 19'h00100;
        rd_sent = 1'b1;
      end
      cycle();
      bus.iRD_REQ = 1'b0;
      n++;
    end
    check("t4_timeout", n < 200, 1'b1);
    cycle();
    first2 = -1;
    last2  = -1;
    foreach (codes[i]) if (codes[i] == 2) begin
      if (first2 < 0) first2 = i;
      last2 = i;
    end
    check("t4_wr_before_rd", count_code(0, 0, first2 - 1), 6);
    check("t4_idle_before",  code_at(first2 - 1), 3);
    check("t4_rd_span",      last2 - first2, BURST - 1);
    check("t4_rd_count",     count_code(2, first2, last2), BURST);
    check("t4_idle_after",   code_at(last2 + 1), 3);
    check("t4_regrant",      code_at(last2 + 2), 0);
    check("t4_wr_total",     acc[0], 40);
    check("t4_wr_err",       wr_err, 0);
    check_burst("t4", 19'h00100);

    // T5a: three stalled cycles in the middle of a write slot
    clear_logs();
    wr_left[0] = 10;
    n = 0;
    while (acc[0] < 3 && n < 20) begin cycle(); n++; end
    check("t5w_reach", acc[0], 3);
    for (int k = 0; k < 3; k++) begin
      bus.iMEM_BUSY = 1'b1;
      cyc_begin();
      check("t5w_wait", bus.oWR0_WAIT, 1'b1);
      check("t5w_addr", bus.oMEM_ADDR, 19'h01000 + 19'd64 + 19'd40 + 19'd3);
      cyc_end();
    end
    bus.iMEM_BUSY = 1'b0;
    n = 0;
    while (wr_left[0] > 0 && n < 40) begin cycle(); n++; end
    check("t5w_count", count_code(0, 0, codes.size() - 1), 10);
    check("t5w_err",   wr_err, 0);

    // T5b: three stalled cycles in the middle of a read burst
    cycle();
    clear_logs();
    bus.iRD_REQ  = 1'b1;
    bus.iRD_ADDR = 19'h3FFF0;
    cycle();
    bus.iRD_REQ = 1'b0;
    n = 0;
    while (rlog.size() < 5 && n < 20) begin cycle(); n++; end
    for (int k = 0; k < 3; k++) begin
      bus.iMEM_BUSY = 1'b1;
      cyc_begin();
      check("t5r_req",  bus.oMEM_REQ, 1'b1);
      check("t5r_addr", bus.oMEM_ADDR, 19'h3FFF5);
      cyc_end();
    end
    bus.iMEM_BUSY = 1'b0;
    wait_rd_done("t5r", 80);
    check_burst("t5r", 19'h3FFF0);

    // T6: reset after 7 issues of a burst, then stray returns
    clear_logs();
    bus.iRD_REQ  = 1'b1;
    bus.iRD_ADDR = 19'h12345;
    cycle();
    bus.iRD_REQ = 1'b0;
    n = 0;
    while (rlog.size() < 7 && n < 20) begin cycle(); n++; end
    check("t6_issued", rlog.size(), 7);
    rst_n = 1'b0;
    cyc_begin();
    check("t6_mem_req",  bus.oMEM_REQ, 1'b0);
    check("t6_mem_addr", bus.oMEM_ADDR, 19'h0);
    check("t6_rd_busy",  bus.oRD_BUSY, 1'b0);
    check("t6_rd_valid", bus.oRD_VALID, 1'b0);
    check("t6_rd_data",  bus.oRD_DATA, 16'h0);
    check("t6_wait0",    bus.oWR0_WAIT, 1'b1);
    cyc_end();
    cycle();
    rst_n = 1'b1;
    rdout.delete();
    codes.delete();
    for (int i = 0; i < 8; i++) begin
      stray = (i == 3 || i == 4);
      cycle();
    end
    stray = 1'b0;
    check("t6_no_fwd",    rdout.size(), 0);
    check("t6_no_read",   count_code(2, 0, codes.size() - 1), 0);
    check("t6_busy_end",  bus.oRD_BUSY, 1'b0);
    check("t6_data_end",  bus.oRD_DATA, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
